control_pipeline: RTL and testbench
===================================

# control_pipeline

Pipelined main control unit for the five-stage MIPS datapath. Decodes opcode/funct in ID and carries the control word through the ID/EX, EX/MEM and MEM/WB registers, so every stage receives its slice of control aligned with its instruction. Detects load-use hazards and multiply/divide HI/LO interlocks and raises `stall`. Accepts a branch/jump `flush` that turns the ID instruction into a bubble.

## Interface
Parameters:
- `REG_W`, 5: register-specifier width.
- `MD_LAT`, 4: mult/div latency in cycles. Legal range 1..15. The counter width is 4 bits.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `id_valid` in 1: the ID instruction is real. When 0 it is decoded as a bubble.
- `opcode` in 6: ID instruction [31:26].
- `funct` in 6: ID instruction [5:0].
- `id_rs` in REG_W: ID rs field.
- `id_rt` in REG_W: ID rt field.
- `flush` in 1: squash the ID instruction (taken branch or jump).
- `stall` out 1: combinational. Hold PC and IF/ID, and insert a bubble into ID/EX.
- `ex_ctrl` out 10: packed {Branch, Jump, JalSignal, Shifter, MFHI, MFLO, RegDst, ALUSrc, ALUOp[1:0]} for bits [9:0].
- `ex_rt` out REG_W: rt of the EX instruction.
- `mem_ctrl` out 2: {MemRead, MemWrite}.
- `wb_ctrl` out 3: {RegWrite, MemtoReg, writeBackSrc}.
- `ex_illegal` out 1: the EX instruction had an unimplemented opcode.

## Operation
- **Decode (combinational, ID).** Opcodes: R=0, LW=35, SW=43, BEQ=4, J=2, JAL=3, SLTI=10.
  - R: RegDst, RegWrite, ALUOp=10. Funct qualifies further: 0 adds Shifter, 16 adds MFHI, 18 adds MFLO.
  - LW: ALUSrc, MemtoReg, RegWrite, MemRead, ALUOp=00.
  - SW: ALUSrc, MemWrite, ALUOp=00.
  - BEQ: Branch, ALUOp=01.
  - J: Jump, ALUOp=01.
  - JAL: Jump, RegWrite, JalSignal, ALUOp=01.
  - SLTI: ALUSrc, RegWrite, writeBackSrc, ALUOp=01.
  - Any other opcode: all-zero control word and illegal=1.
- **Bubble.** A bubble is an all-zero control word with illegal=0 and rt=0.
- **ID/EX load.** ID/EX loads a bubble when `flush`, `stall`, or `!id_valid`. Otherwise it loads the decoded word.
- **Downstream registers.** EX/MEM and MEM/WB always advance; they are never stalled.
- **Load-use hazard.** Raised when EX MemRead=1, `ex_rt`≠0, and (`ex_rt`==`id_rs` or `ex_rt`==`id_rt`) while `id_valid`. It is a one-cycle stall.
- **Mult/div busy counter (`md_cnt`).**
  - Loaded with MD_LAT when a valid, unflushed, unstalled R instruction with funct 24–27 enters ID/EX.
  - Otherwise it decrements while nonzero and saturates at 0.
  - A new mult/div reloads the counter regardless of its current value.
- **HI/LO interlock.** `stall`=1 while the ID instruction is a valid MFHI or MFLO and `md_cnt`≠0.
- **Stall composition.** `stall` = (load-use | HI/LO interlock) & !`flush`. Flush has priority, because the stalled instruction is being discarded.

## Timing
- **Reset.** Every output register, and `md_cnt`, goes to 0: `ex_ctrl`, `ex_rt`, `mem_ctrl`, `wb_ctrl` and `ex_illegal`. The `stall` output is therefore 0 after reset.
- **Latency.** Instruction decoded in ID at cycle n:
  - `ex_ctrl` is valid in cycle n+1.
  - `mem_ctrl` is valid in n+2.
  - `wb_ctrl` is valid in n+3.
  - MFHI/MFLO travel with the EX word.
- **`stall` timing.** Same-cycle combinational from `opcode`, `funct`, `id_rs`, `id_rt`, `id_valid`, `flush` and the registered state.
- **Mult/div window.** A mult/div entering EX at n+1 blocks MFHI/MFLO in ID from cycles n+1 through n+MD_LAT. The MFHI/MFLO is allowed at n+MD_LAT+1.
- **Mid-operation reset.** Reset mid-operation clears in-flight words and `md_cnt` on the same edge; no stall persists.
- **Simultaneous load-use and interlock.** Still one `stall`; the instruction is released when both conditions clear.

## Configuration
- **`CTRL_MD_INTERLOCK_EN` defined.** The `md_cnt` counter and the HI/LO interlock are built as described.
- **`CTRL_MD_INTERLOCK_EN` undefined.**
  - The counter is removed.
  - `stall` = load-use & !`flush` only.
  - MD_LAT is ignored, and software is responsible for HI/LO spacing.

## Test plan
- **Reset and LW.** Reset, then LW (op 35) with `id_valid`=1.
  - At n+1: `ex_ctrl`=10'b0000000100.
  - At n+2: `mem_ctrl`=2'b10.
  - At n+3: `wb_ctrl`=3'b110.
- **Load-use.** LW with rt=8, followed by R-type with rs=8: `stall`=1 for exactly one cycle and a bubble appears in `ex_ctrl`. The same case with rt=0 gives `stall`=0.
- **Flush.** BEQ then `flush`=1 with SW in ID: the next `ex_ctrl`=0 and `mem_ctrl` 2 cycles later =0; `stall` stays 0 even if a load-use condition holds.
- **HI/LO interlock (MD_LAT=4, macro on).** MULT (funct 24) then MFLO: `stall`=1 for 4 cycles, then MFLO enters EX with MFLO bit (bit4)=1. With the macro off, `stall`=0.
- **Illegal opcode.** Opcode 63: `ex_illegal`=1 and an all-zero control word. SLTI gives `wb_ctrl`=3'b101 and ALUOp=01.
- **Reset mid-operation.** Assert `rst` mid-interlock: `md_cnt`=0, all outputs 0 and `stall`=0 on the next cycle.

Source files
------------

// File: rtl/control_pipeline.sv
// Pipelined MIPS main control: ID decode carried through ID/EX, EX/MEM, MEM/WB with
// load-use and HI/LO hazard stalls. Optional mult/div interlock: CTRL_MD_INTERLOCK_EN.
module control_pipeline #(
    parameter int REG_W  = 5,
    parameter int MD_LAT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             flush,
    output logic             stall,
    output logic [9:0]       ex_ctrl,
    output logic [REG_W-1:0] ex_rt,
    output logic [1:0]       mem_ctrl,
    output logic [2:0]       wb_ctrl,
    output logic             ex_illegal
);

    localparam logic [5:0] OP_R    = 6'd0;
    localparam logic [5:0] OP_LW   = 6'd35;
    localparam logic [5:0] OP_SW   = 6'd43;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_J    = 6'd2;
    localparam logic [5:0] OP_JAL  = 6'd3;
    localparam logic [5:0] OP_SLTI = 6'd10;

    localparam logic [5:0] FN_SLL  = 6'd0;
    localparam logic [5:0] FN_MFHI = 6'd16;
    localparam logic [5:0] FN_MFLO = 6'd18;

    if (MD_LAT < 1 || MD_LAT > 15) begin : g_bad_md_lat
        $error("control_pipeline: MD_LAT must be in 1..15");
    end

    logic [9:0] dec_ex;
    logic [1:0] dec_mem;
    logic [2:0] dec_wb;
    logic       dec_illegal;

    // ex bits: {Branch, Jump, JalSignal, Shifter, MFHI, MFLO, RegDst, ALUSrc, ALUOp[1:0]}
    always_comb begin
        dec_ex      = '0;
        dec_mem     = '0;
        dec_wb      = '0;
        dec_illegal = 1'b0;
        case (opcode)
            OP_R: begin
                dec_ex[3]   = 1'b1;
                dec_ex[1:0] = 2'b10;
                dec_wb[2]   = 1'b1;
                dec_ex[6]   = (funct == FN_SLL);
                dec_ex[5]   = (funct == FN_MFHI);
                dec_ex[4]   = (funct == FN_MFLO);
            end
            OP_LW: begin
                dec_ex[2]   = 1'b1;
                dec_mem[1]  = 1'b1;
                dec_wb[2:1] = 2'b11;
            end
            OP_SW: begin
                dec_ex[2]  = 1'b1;
                dec_mem[0] = 1'b1;
            end
            OP_BEQ: begin
                dec_ex[9]   = 1'b1;
                dec_ex[1:0] = 2'b01;
            end
            OP_J: begin
                dec_ex[8]   = 1'b1;
                dec_ex[1:0] = 2'b01;
            end
            OP_JAL: begin
                dec_ex[8]   = 1'b1;
                dec_ex[7]   = 1'b1;
                dec_ex[1:0] = 2'b01;
                dec_wb[2]   = 1'b1;
            end
            OP_SLTI: begin
                dec_ex[2]   = 1'b1;
                dec_ex[1:0] = 2'b01;
                dec_wb[2]   = 1'b1;
                dec_wb[0]   = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    logic [1:0] ex_mem_ctrl;
    logic [2:0] ex_wb_ctrl;
    logic [2:0] mem_wb_ctrl;
    logic       load_use;
    logic       bubble;

    assign load_use = id_valid && ex_mem_ctrl[1] && (ex_rt != '0) &&
                      ((ex_rt == id_rs) || (ex_rt == id_rt));

`ifdef CTRL_MD_INTERLOCK_EN
    localparam logic [3:0] MD_INIT = 4'(MD_LAT);

    logic [3:0] md_cnt;
    logic       hilo_stall;
    logic       md_start;

    assign hilo_stall = id_valid && (opcode == OP_R) &&
                        ((funct == FN_MFHI) || (funct == FN_MFLO)) && (md_cnt != 4'd0);
    assign stall      = (load_use || hilo_stall) && !flush;
    assign md_start   = id_valid && !flush && !stall && (opcode == OP_R) &&
                        (funct[5:2] == 4'b0110);

    // A new mult/div restarts the busy window even if one is still running.
    always_ff @(posedge clk) begin
        if (rst) begin
            md_cnt <= 4'd0;
        end else if (md_start) begin
            md_cnt <= MD_INIT;
        end else if (md_cnt != 4'd0) begin
            md_cnt <= md_cnt - 4'd1;
        end
    end
`else
    assign stall = load_use && !flush;
`endif

    assign bubble = flush || stall || !id_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_ctrl     <= '0;
            ex_mem_ctrl <= '0;
            ex_wb_ctrl  <= '0;
            ex_rt       <= '0;
            ex_illegal  <= 1'b0;
        end else if (bubble) begin
            ex_ctrl     <= '0;
            ex_mem_ctrl <= '0;
            ex_wb_ctrl  <= '0;
            ex_rt       <= '0;
            ex_illegal  <= 1'b0;
        end else begin
            ex_ctrl     <= dec_ex;
            ex_mem_ctrl <= dec_mem;
            ex_wb_ctrl  <= dec_wb;
            ex_rt       <= id_rt;
            ex_illegal  <= dec_illegal;
        end
    end

    // EX/MEM and MEM/WB never stall; a held ID only injects bubbles upstream of them.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_ctrl    <= '0;
            mem_wb_ctrl <= '0;
            wb_ctrl     <= '0;
        end else begin
            mem_ctrl    <= ex_mem_ctrl;
            mem_wb_ctrl <= ex_wb_ctrl;
            wb_ctrl     <= mem_wb_ctrl;
        end
    end

endmodule

// File: tb/tb_control_pipeline.sv
// Self-checking bench for control_pipeline: directed test-plan cases with literal
// expectations, then randomized traffic against a cycle-indexed behavioural model.
module tb_control_pipeline;

    localparam int REG_W  = 5;
    localparam int MD_LAT = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             flush;
    logic             stall;
    logic [9:0]       ex_ctrl;
    logic [REG_W-1:0] ex_rt;
    logic [1:0]       mem_ctrl;
    logic [2:0]       wb_ctrl;
    logic             ex_illegal;

    control_pipeline #(.REG_W(REG_W), .MD_LAT(MD_LAT)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .opcode(opcode), .funct(funct),
        .id_rs(id_rs), .id_rt(id_rt), .flush(flush), .stall(stall), .ex_ctrl(ex_ctrl),
        .ex_rt(ex_rt), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl), .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0]       ctrl;
        logic [1:0]       mem;
        logic [2:0]       wb;
        logic [REG_W-1:0] rt;
        logic             ill;
    } word_t;

    // pipe[0] = word in EX, pipe[1] = word in MEM, pipe[2] = word in WB
    word_t pipe [3];
    int    cycle;
    int    mult_cycle;
    int    total;
    int    passed;

    function automatic word_t decode(input logic [5:0] op, input logic [5:0] fn,
                                     input logic [REG_W-1:0] rt);
        word_t w;
        w = '0;
        w.rt = rt;
        case (op)
            6'd0: begin
                w.ctrl = 10'b0000001010;
                if (fn == 6'd0)  w.ctrl = 10'b0001001010;
                if (fn == 6'd16) w.ctrl = 10'b0000101010;
                if (fn == 6'd18) w.ctrl = 10'b0000011010;
                w.wb = 3'b100;
            end
            6'd35: begin w.ctrl = 10'b0000000100; w.mem = 2'b10; w.wb = 3'b110; end
            6'd43: begin w.ctrl = 10'b0000000100; w.mem = 2'b01; end
            6'd4:  w.ctrl = 10'b1000000001;
            6'd2:  w.ctrl = 10'b0100000001;
            6'd3:  begin w.ctrl = 10'b0110000001; w.wb = 3'b100; end
            6'd10: begin w.ctrl = 10'b0000000101; w.wb = 3'b101; end
            default: w.ill = 1'b1;
        endcase
        return w;
    endfunction

    function automatic logic model_stall();
        logic lu, il;
        lu = id_valid && pipe[0].mem[1] && (pipe[0].rt != 0) &&
             ((pipe[0].rt == id_rs) || (pipe[0].rt == id_rt));
        il = 1'b0;
`ifdef CTRL_MD_INTERLOCK_EN
        il = id_valid && (opcode == 6'd0) && ((funct == 6'd16) || (funct == 6'd18)) &&
             (cycle >= mult_cycle + 1) && (cycle <= mult_cycle + MD_LAT);
`endif
        return (lu || il) && !flush;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s at cycle %0d: got 'h%0h, expected 'h%0h", name, cycle, act, exp);
    endtask

    task automatic applyStimulus(input logic r, input logic v, input logic [5:0] op,
                                 input logic [5:0] fn, input logic [REG_W-1:0] rs,
                                 input logic [REG_W-1:0] rt, input logic fl);
        rst = r; id_valid = v; opcode = op; funct = fn; id_rs = rs; id_rt = rt; flush = fl;
        @(negedge clk);
        checkOutput();
    endtask

    task automatic checkOutput();
        check("stall",      32'(stall),      32'(model_stall()));
        check("ex_ctrl",    32'(ex_ctrl),    32'(pipe[0].ctrl));
        check("ex_rt",      32'(ex_rt),      32'(pipe[0].rt));
        check("ex_illegal", 32'(ex_illegal), 32'(pipe[0].ill));
        check("mem_ctrl",   32'(mem_ctrl),   32'(pipe[1].mem));
        check("wb_ctrl",    32'(wb_ctrl),    32'(pipe[2].wb));
    endtask

    task automatic tick();
        logic  st;
        word_t w;
        st = model_stall();
        @(posedge clk);
        if (rst) begin
            pipe[0] = '0; pipe[1] = '0; pipe[2] = '0;
            mult_cycle = -1000;
        end else begin
            w = '0;
            if (id_valid && !flush && !st) begin
                w = decode(opcode, funct, id_rt);
                if (opcode == 6'd0 && funct >= 6'd24 && funct <= 6'd27) mult_cycle = cycle;
            end
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = w;
        end
        cycle++;
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 6'd0, 6'd0, 0, 0, 0);
    endtask

    initial begin
        logic [5:0] ops [9];
        logic [5:0] fns [10];
        ops = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd2, 6'd3, 6'd10, 6'd63, 6'd17};
        fns = '{6'd0, 6'd16, 6'd18, 6'd24, 6'd25, 6'd26, 6'd27, 6'd32, 6'd34, 6'd42};
        total = 0; passed = 0; cycle = 0; mult_cycle = -1000;
        pipe[0] = '0; pipe[1] = '0; pipe[2] = '0;

        applyStimulus(1, 0, 0, 0, 0, 0, 0); tick();
        applyStimulus(1, 0, 0, 0, 0, 0, 0); tick();
        idle();
        check("reset ex_ctrl", 32'(ex_ctrl), 0);
        check("reset stall", 32'(stall), 0);
        tick();

        // LW propagation
        applyStimulus(0, 1, 6'd35, 0, 5'd1, 5'd8, 0); tick();
        idle(); check("lw ex_ctrl", 32'(ex_ctrl), 32'(10'b0000000100)); tick();
        idle(); check("lw mem_ctrl", 32'(mem_ctrl), 32'(2'b10)); tick();
        idle(); check("lw wb_ctrl", 32'(wb_ctrl), 32'(3'b110)); tick();

        // load-use hazard and its rt=0 exception
        applyStimulus(0, 1, 6'd35, 0, 5'd1, 5'd8, 0); tick();
        applyStimulus(0, 1, 6'd0, 6'd32, 5'd8, 5'd3, 0);
        check("lu stall", 32'(stall), 1); tick();
        applyStimulus(0, 1, 6'd0, 6'd32, 5'd8, 5'd3, 0);
        check("lu released", 32'(stall), 0);
        check("lu bubble", 32'(ex_ctrl), 0); tick();
        idle(); check("lu r-type ex", 32'(ex_ctrl), 32'(10'b0000001010)); tick();
        applyStimulus(0, 1, 6'd35, 0, 5'd1, 5'd0, 0); tick();
        applyStimulus(0, 1, 6'd0, 6'd32, 5'd0, 5'd2, 0);
        check("lu rt0 stall", 32'(stall), 0); tick();

        // flush beats a pending load-use
        applyStimulus(0, 1, 6'd4, 0, 5'd1, 5'd2, 0); tick();
        applyStimulus(0, 1, 6'd35, 0, 5'd1, 5'd5, 0); tick();
        applyStimulus(0, 1, 6'd43, 0, 5'd5, 5'd6, 1);
        check("flush stall", 32'(stall), 0); tick();
        idle(); check("flush ex_ctrl", 32'(ex_ctrl), 0); tick();
        idle(); tick();
        idle(); check("flush wb", 32'(wb_ctrl), 0); tick();

        // MULT then MFLO
        applyStimulus(0, 1, 6'd0, 6'd24, 5'd1, 5'd2, 0); tick();
`ifdef CTRL_MD_INTERLOCK_EN
        for (int i = 0; i < MD_LAT; i++) begin
            applyStimulus(0, 1, 6'd0, 6'd18, 5'd0, 5'd0, 0);
            check("hilo stall", 32'(stall), 1); tick();
        end
`endif
        applyStimulus(0, 1, 6'd0, 6'd18, 5'd0, 5'd0, 0);
        check("hilo release", 32'(stall), 0); tick();
        idle(); check("mflo bit", 32'(ex_ctrl[4]), 1); tick();

        // illegal opcode, SLTI
        applyStimulus(0, 1, 6'd63, 0, 5'd1, 5'd2, 0); tick();
        idle();
        check("illegal flag", 32'(ex_illegal), 1);
        check("illegal ctrl", 32'(ex_ctrl), 0); tick();
        applyStimulus(0, 1, 6'd10, 0, 5'd1, 5'd2, 0); tick();
        idle(); check("slti aluop", 32'(ex_ctrl[1:0]), 32'(2'b01)); tick();
        idle(); tick();
        idle(); check("slti wb", 32'(wb_ctrl), 32'(3'b101)); tick();

        // reset during an interlock window
        applyStimulus(0, 1, 6'd0, 6'd25, 5'd1, 5'd2, 0); tick();
        applyStimulus(0, 1, 6'd0, 6'd16, 5'd0, 5'd0, 0); tick();
        applyStimulus(1, 1, 6'd0, 6'd16, 5'd0, 5'd0, 0); tick();
        applyStimulus(0, 1, 6'd0, 6'd16, 5'd0, 5'd0, 0);
        check("mid-reset stall", 32'(stall), 0);
        check("mid-reset ex", 32'(ex_ctrl), 0);
        check("mid-reset mem", 32'(mem_ctrl), 0);
        check("mid-reset wb", 32'(wb_ctrl), 0);
        tick();

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [5:0] op;
            op = ops[$urandom_range(0, 8)];
            applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 85), op,
                          (op == 6'd0) ? fns[$urandom_range(0, 9)] : 6'($urandom),
                          REG_W'($urandom_range(0, 3)), REG_W'($urandom_range(0, 3)),
                          ($urandom_range(0, 9) == 0));
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
